// File: rtl/scaler_coef_lut_pkg.sv
// Shared types and width helpers for the scaler coefficient LUT stage.
package scaler_coef_lut_pkg;

    // Bank swap request tracking: a request waits in SWAP_PEND until a frame boundary.
    typedef enum logic [0:0] {
        SWAP_IDLE = 1'b0,
        SWAP_PEND = 1'b1
    } swap_state_t;

    // Ceiling log2 of value (number of bits needed to index value entries).
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 32'sd0;
        remaining = value - 32'sd1;
        while (remaining > 32'sd0) begin
            result    = result + 32'sd1;
            remaining = remaining >>> 1;
        end
        return result;
    endfunction

    // Index width for a table of depth entries, never narrower than one bit.
    function automatic int idx_width(input int depth);
        int w;
        w = clog2(depth);
        if (w < 32'sd1) begin
            w = 32'sd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/scaler_coef_lut_bank.sv
// One PHASE_NUM-deep coefficient table: registered rows, indexed write port,
// combinational read that returns zero for phases beyond the table.
module scaler_coef_bank
    import scaler_coef_lut_pkg::*;
#(
    parameter int PHASE_NUM      = 16,
    parameter int ROW_W          = 32,
    parameter int PHASE_BITWIDTH = idx_width(PHASE_NUM)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [PHASE_BITWIDTH-1:0] wr_phase,
    input  logic [ROW_W-1:0]          wr_data,
    input  logic [PHASE_BITWIDTH-1:0] rd_phase,
    output logic [ROW_W-1:0]          rd_data
);

    localparam logic [31:0] PHASE_LIMIT = 32'(PHASE_NUM);

    logic [ROW_W-1:0] table_r [PHASE_NUM];
    logic             wr_in_range_s;
    logic             rd_in_range_s;

    assign wr_in_range_s = (32'(wr_phase) < PHASE_LIMIT);
    assign rd_in_range_s = (32'(rd_phase) < PHASE_LIMIT);

    // Table storage: cleared on reset, out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < PHASE_NUM; i++) begin
                table_r[i] <= {ROW_W{1'b0}};
            end
        end else if (wr_en && wr_in_range_s) begin
            table_r[wr_phase] <= wr_data;
        end
    end

    // Row lookup; an out-of-range phase yields an all-zero coefficient vector.
    always_comb begin
        rd_data = {ROW_W{1'b0}};
        if (rd_in_range_s) begin
            rd_data = table_r[rd_phase];
        end else begin
            rd_data = {ROW_W{1'b0}};
        end
    end

endmodule

// File: rtl/scaler_coef_lut.sv
// Double-buffered H/V polyphase coefficient tables with a frame-aligned bank
// swap, plus a 2-stage valid/ready pipeline that pairs each pixel matrix with
// the coefficient rows selected by its H/V phase.
module scaler_coef_lut
    import scaler_coef_lut_pkg::*;
#(
    parameter int PIXEL_BITWIDTH       = 8,
    parameter int KERNEL_MAX           = 4,
    parameter int KERNEL_COEF_BITWIDTH = 8,
    parameter int PHASE_NUM            = 16,
    parameter int PHASE_BITWIDTH       = idx_width(PHASE_NUM)
) (
    input  logic                                             core_clk,
    input  logic                                             core_rst_n,
    input  logic                                             cfg_coef_wr_en,
    input  logic                                             cfg_coef_wr_sel,
    input  logic [PHASE_BITWIDTH-1:0]                        cfg_coef_wr_phase,
    input  logic [KERNEL_COEF_BITWIDTH*KERNEL_MAX-1:0]       cfg_coef_wr_data,
    input  logic                                             cfg_bank_swap_req,
    output logic                                             cfg_bank_swap_pend,
    output logic                                             cfg_active_bank,
    input  logic                                             frame_start,
    input  logic                                             s_axis_valid,
    output logic                                             s_axis_ready,
    input  logic [PIXEL_BITWIDTH*KERNEL_MAX*KERNEL_MAX-1:0]  s_axis_pixel,
    input  logic [PHASE_BITWIDTH-1:0]                        s_axis_phase_h,
    input  logic [PHASE_BITWIDTH-1:0]                        s_axis_phase_v,
    input  logic                                             s_axis_last,
    output logic                                             m_axis_valid,
    input  logic                                             m_axis_ready,
    output logic [PIXEL_BITWIDTH*KERNEL_MAX*KERNEL_MAX-1:0]  m_axis_pixel,
    output logic [KERNEL_COEF_BITWIDTH*KERNEL_MAX-1:0]       m_axis_coef_h,
    output logic [KERNEL_COEF_BITWIDTH*KERNEL_MAX-1:0]       m_axis_coef_v,
    output logic                                             m_axis_last,
    output logic                                             err_phase_oor
);

    localparam int          COEF_ROW_W  = KERNEL_COEF_BITWIDTH * KERNEL_MAX;
    localparam int          MATRIX_W    = PIXEL_BITWIDTH * KERNEL_MAX * KERNEL_MAX;
    localparam logic [31:0] PHASE_LIMIT = 32'(PHASE_NUM);

    // Swap control
    swap_state_t swap_state_r;
    swap_state_t swap_state_s;
    logic        toggle_s;
    logic        active_bank_r;

    // Shadow-bank write enables (bankN_H/V)
    logic wr_b0_h_s;
    logic wr_b0_v_s;
    logic wr_b1_h_s;
    logic wr_b1_v_s;

    // Pipeline
    logic                      en_s;
    logic                      accept_s;
    logic                      s1_valid_r;
    logic [MATRIX_W-1:0]       s1_pixel_r;
    logic [PHASE_BITWIDTH-1:0] s1_phase_h_r;
    logic [PHASE_BITWIDTH-1:0] s1_phase_v_r;
    logic                      s1_last_r;
    logic                      s1_bank_r;
    logic                      m_valid_r;
    logic [MATRIX_W-1:0]       m_pixel_r;
    logic [COEF_ROW_W-1:0]     m_coef_h_r;
    logic [COEF_ROW_W-1:0]     m_coef_v_r;
    logic                      m_last_r;
    logic                      err_r;

    // Lookup results
    logic [COEF_ROW_W-1:0] b0_h_rd_s;
    logic [COEF_ROW_W-1:0] b0_v_rd_s;
    logic [COEF_ROW_W-1:0] b1_h_rd_s;
    logic [COEF_ROW_W-1:0] b1_v_rd_s;
    logic [COEF_ROW_W-1:0] coef_h_s;
    logic [COEF_ROW_W-1:0] coef_v_s;
    logic                  oor_s;

    // Writes go to the bank not currently feeding lookups; in a swap cycle the
    // pre-swap value of active_bank_r decides, so the write lands in the old shadow.
    assign wr_b0_h_s = cfg_coef_wr_en &  active_bank_r & ~cfg_coef_wr_sel;
    assign wr_b0_v_s = cfg_coef_wr_en &  active_bank_r &  cfg_coef_wr_sel;
    assign wr_b1_h_s = cfg_coef_wr_en & ~active_bank_r & ~cfg_coef_wr_sel;
    assign wr_b1_v_s = cfg_coef_wr_en & ~active_bank_r &  cfg_coef_wr_sel;

    scaler_coef_bank #(.PHASE_NUM(PHASE_NUM), .ROW_W(COEF_ROW_W), .PHASE_BITWIDTH(PHASE_BITWIDTH)) u_bank0_h (
        .clk(core_clk), .rst_n(core_rst_n), .wr_en(wr_b0_h_s), .wr_phase(cfg_coef_wr_phase),
        .wr_data(cfg_coef_wr_data), .rd_phase(s1_phase_h_r), .rd_data(b0_h_rd_s)
    );
    scaler_coef_bank #(.PHASE_NUM(PHASE_NUM), .ROW_W(COEF_ROW_W), .PHASE_BITWIDTH(PHASE_BITWIDTH)) u_bank0_v (
        .clk(core_clk), .rst_n(core_rst_n), .wr_en(wr_b0_v_s), .wr_phase(cfg_coef_wr_phase),
        .wr_data(cfg_coef_wr_data), .rd_phase(s1_phase_v_r), .rd_data(b0_v_rd_s)
    );
    scaler_coef_bank #(.PHASE_NUM(PHASE_NUM), .ROW_W(COEF_ROW_W), .PHASE_BITWIDTH(PHASE_BITWIDTH)) u_bank1_h (
        .clk(core_clk), .rst_n(core_rst_n), .wr_en(wr_b1_h_s), .wr_phase(cfg_coef_wr_phase),
        .wr_data(cfg_coef_wr_data), .rd_phase(s1_phase_h_r), .rd_data(b1_h_rd_s)
    );
    scaler_coef_bank #(.PHASE_NUM(PHASE_NUM), .ROW_W(COEF_ROW_W), .PHASE_BITWIDTH(PHASE_BITWIDTH)) u_bank1_v (
        .clk(core_clk), .rst_n(core_rst_n), .wr_en(wr_b1_v_s), .wr_phase(cfg_coef_wr_phase),
        .wr_data(cfg_coef_wr_data), .rd_phase(s1_phase_v_r), .rd_data(b1_v_rd_s)
    );

    // Swap next-state: a request is applied at the first frame_start (including its own cycle);
    // extra requests while pending are absorbed.
    always_comb begin
        swap_state_s = swap_state_r;
        toggle_s     = 1'b0;
        case (swap_state_r)
            SWAP_IDLE: begin
                if (cfg_bank_swap_req && frame_start) begin
                    toggle_s     = 1'b1;
                    swap_state_s = SWAP_IDLE;
                end else if (cfg_bank_swap_req) begin
                    swap_state_s = SWAP_PEND;
                end else begin
                    swap_state_s = SWAP_IDLE;
                end
            end
            SWAP_PEND: begin
                if (frame_start) begin
                    toggle_s     = 1'b1;
                    swap_state_s = SWAP_IDLE;
                end else begin
                    swap_state_s = SWAP_PEND;
                end
            end
            default: begin
                swap_state_s = SWAP_IDLE;
            end
        endcase
    end

    // Swap state and active-bank registers.
    always_ff @(posedge core_clk) begin
        if (!core_rst_n) begin
            swap_state_r  <= SWAP_IDLE;
            active_bank_r <= 1'b0;
        end else begin
            swap_state_r <= swap_state_s;
            if (toggle_s) begin
                active_bank_r <= ~active_bank_r;
            end
        end
    end

    // One global enable: the whole pipe advances whenever the output slot is free or draining.
    assign en_s     = ~m_valid_r | m_axis_ready;
    assign accept_s = s_axis_valid & en_s;
    assign oor_s    = (32'(s_axis_phase_h) >= PHASE_LIMIT) | (32'(s_axis_phase_v) >= PHASE_LIMIT);

    // Stage 1: capture the beat together with the bank that is active when it is accepted.
    always_ff @(posedge core_clk) begin
        if (!core_rst_n) begin
            s1_valid_r   <= 1'b0;
            s1_pixel_r   <= {MATRIX_W{1'b0}};
            s1_phase_h_r <= {PHASE_BITWIDTH{1'b0}};
            s1_phase_v_r <= {PHASE_BITWIDTH{1'b0}};
            s1_last_r    <= 1'b0;
            s1_bank_r    <= 1'b0;
        end else if (en_s) begin
            s1_valid_r <= s_axis_valid;
            if (s_axis_valid) begin
                s1_pixel_r   <= s_axis_pixel;
                s1_phase_h_r <= s_axis_phase_h;
                s1_phase_v_r <= s_axis_phase_v;
                s1_last_r    <= s_axis_last;
                s1_bank_r    <= active_bank_r;
            end
        end
    end

    assign coef_h_s = s1_bank_r ? b1_h_rd_s : b0_h_rd_s;
    assign coef_v_s = s1_bank_r ? b1_v_rd_s : b0_v_rd_s;

    // Stage 2: register the looked-up rows; everything holds while stalled.
    always_ff @(posedge core_clk) begin
        if (!core_rst_n) begin
            m_valid_r  <= 1'b0;
            m_pixel_r  <= {MATRIX_W{1'b0}};
            m_coef_h_r <= {COEF_ROW_W{1'b0}};
            m_coef_v_r <= {COEF_ROW_W{1'b0}};
            m_last_r   <= 1'b0;
        end else if (en_s) begin
            m_valid_r <= s1_valid_r;
            m_last_r  <= s1_valid_r & s1_last_r;
            if (s1_valid_r) begin
                m_pixel_r  <= s1_pixel_r;
                m_coef_h_r <= coef_h_s;
                m_coef_v_r <= coef_v_s;
            end
        end
    end

    // Sticky flag for any accepted beat carrying a phase outside the table.
    always_ff @(posedge core_clk) begin
        if (!core_rst_n) begin
            err_r <= 1'b0;
        end else if (accept_s && oor_s) begin
            err_r <= 1'b1;
        end
    end

    assign s_axis_ready       = en_s;
    assign m_axis_valid       = m_valid_r;
    assign m_axis_pixel       = m_pixel_r;
    assign m_axis_coef_h      = m_coef_h_r;
    assign m_axis_coef_v      = m_coef_v_r;
    assign m_axis_last        = m_last_r;
    assign err_phase_oor      = err_r;
    assign cfg_bank_swap_pend = (swap_state_r == SWAP_PEND);
    assign cfg_active_bank    = active_bank_r;

endmodule

// File: tb/tb_scaler_coef_lut.sv
// Directed bench for scaler_coef_lut built with a 12-phase table so that
// out-of-range phases (12..15) are reachable with the 4-bit phase index.
module tb_scaler_coef_lut;

    localparam int PW    = 4;
    localparam int ROW_W = 32;
    localparam int MAT_W = 128;

    logic             core_clk = 1'b0;
    logic             core_rst_n = 1'b0;
    logic             cfg_coef_wr_en = 1'b0;
    logic             cfg_coef_wr_sel = 1'b0;
    logic [PW-1:0]    cfg_coef_wr_phase = '0;
    logic [ROW_W-1:0] cfg_coef_wr_data = '0;
    logic             cfg_bank_swap_req = 1'b0;
    logic             cfg_bank_swap_pend;
    logic             cfg_active_bank;
    logic             frame_start = 1'b0;
    logic             s_axis_valid = 1'b0;
    logic             s_axis_ready;
    logic [MAT_W-1:0] s_axis_pixel = '0;
    logic [PW-1:0]    s_axis_phase_h = '0;
    logic [PW-1:0]    s_axis_phase_v = '0;
    logic             s_axis_last = 1'b0;
    logic             m_axis_valid;
    logic             m_axis_ready = 1'b1;
    logic [MAT_W-1:0] m_axis_pixel;
    logic [ROW_W-1:0] m_axis_coef_h;
    logic [ROW_W-1:0] m_axis_coef_v;
    logic             m_axis_last;
    logic             err_phase_oor;

    int errors = 0;
    int checks = 0;

    scaler_coef_lut #(
        .PIXEL_BITWIDTH(8), .KERNEL_MAX(4), .KERNEL_COEF_BITWIDTH(8), .PHASE_NUM(12)
    ) dut (
        .core_clk(core_clk), .core_rst_n(core_rst_n),
        .cfg_coef_wr_en(cfg_coef_wr_en), .cfg_coef_wr_sel(cfg_coef_wr_sel),
        .cfg_coef_wr_phase(cfg_coef_wr_phase), .cfg_coef_wr_data(cfg_coef_wr_data),
        .cfg_bank_swap_req(cfg_bank_swap_req), .cfg_bank_swap_pend(cfg_bank_swap_pend),
        .cfg_active_bank(cfg_active_bank), .frame_start(frame_start),
        .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready), .s_axis_pixel(s_axis_pixel),
        .s_axis_phase_h(s_axis_phase_h), .s_axis_phase_v(s_axis_phase_v), .s_axis_last(s_axis_last),
        .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready), .m_axis_pixel(m_axis_pixel),
        .m_axis_coef_h(m_axis_coef_h), .m_axis_coef_v(m_axis_coef_v), .m_axis_last(m_axis_last),
        .err_phase_oor(err_phase_oor)
    );

    always #5 core_clk = ~core_clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    // Drive one cycle of configuration inputs, then return them to idle.
    task automatic drive_cfg(input logic wr, input logic sel, input logic [PW-1:0] ph,
                             input logic [ROW_W-1:0] data, input logic req, input logic fs);
        cfg_coef_wr_en = wr; cfg_coef_wr_sel = sel; cfg_coef_wr_phase = ph;
        cfg_coef_wr_data = data; cfg_bank_swap_req = req; frame_start = fs;
        @(posedge core_clk); #1;
        cfg_coef_wr_en = 1'b0; cfg_bank_swap_req = 1'b0; frame_start = 1'b0;
    endtask

    // Push a single beat through an idle pipe and capture what comes out (bounded wait).
    task automatic run_beat(input logic [PW-1:0] ph_h, input logic [PW-1:0] ph_v,
                            input logic [MAT_W-1:0] pix, input logic lst,
                            output logic got, output int lat, output logic [MAT_W-1:0] pix_o,
                            output logic [ROW_W-1:0] ch_o, output logic [ROW_W-1:0] cv_o,
                            output logic last_o);
        got = 1'b0; lat = 0; pix_o = '0; ch_o = '0; cv_o = '0; last_o = 1'b0;
        m_axis_ready = 1'b1;
        s_axis_valid = 1'b1; s_axis_phase_h = ph_h; s_axis_phase_v = ph_v;
        s_axis_pixel = pix; s_axis_last = lst;
        @(posedge core_clk); #1;
        s_axis_valid = 1'b0; s_axis_last = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (m_axis_valid) begin
                got = 1'b1; pix_o = m_axis_pixel; ch_o = m_axis_coef_h;
                cv_o = m_axis_coef_v; last_o = m_axis_last;
                break;
            end
            @(posedge core_clk); #1;
            lat++;
        end
        if (got) begin
            @(posedge core_clk); #1;
        end
    endtask

    task automatic test_reset();
        core_rst_n = 1'b0;
        repeat (3) @(posedge core_clk);
        #1;
        checks++; if (m_axis_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", m_axis_valid); end
        checks++; if (cfg_active_bank !== 1'b0) begin errors++; $display("FAIL reset_bank: got %b want 0", cfg_active_bank); end
        checks++; if (cfg_bank_swap_pend !== 1'b0) begin errors++; $display("FAIL reset_pend: got %b want 0", cfg_bank_swap_pend); end
        checks++; if (err_phase_oor !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_phase_oor); end
        checks++; if ({m_axis_pixel, m_axis_coef_h, m_axis_coef_v, m_axis_last} !== '0) begin
            errors++; $display("FAIL reset_data: got pix=%h h=%h v=%h last=%b want all 0", m_axis_pixel, m_axis_coef_h, m_axis_coef_v, m_axis_last);
        end
        core_rst_n = 1'b1;
        @(posedge core_clk); #1;
        checks++; if (s_axis_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", s_axis_ready); end
    endtask

    task automatic test_zero_tables();
        logic got; int lat; logic [MAT_W-1:0] p; logic [ROW_W-1:0] h, v; logic l;
        run_beat(4'd3, 4'd5, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 1'b0, got, lat, p, h, v, l);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL zero_got: got %b want 1", got); end
        checks++; if (lat != 1) begin errors++; $display("FAIL zero_latency: got %0d want 1 edge after accept edge", lat); end
        checks++; if (h !== 32'h0) begin errors++; $display("FAIL zero_coef_h: got %h want 00000000", h); end
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL zero_coef_v: got %h want 00000000", v); end
        checks++; if (p !== 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677) begin errors++; $display("FAIL zero_pixel: got %h", p); end
        checks++; if (m_axis_valid !== 1'b0) begin errors++; $display("FAIL zero_no_dup: got valid %b want 0", m_axis_valid); end
    endtask

    task automatic test_load_swap();
        logic got; int lat; logic [MAT_W-1:0] p; logic [ROW_W-1:0] h, v; logic l;
        drive_cfg(1'b1, 1'b0, 4'd3, 32'h1020_3040, 1'b0, 1'b0);
        drive_cfg(1'b1, 1'b1, 4'd5, 32'h0102_0304, 1'b0, 1'b0);
        drive_cfg(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1);
        checks++; if (cfg_active_bank !== 1'b0) begin errors++; $display("FAIL fs_no_pend: bank got %b want 0", cfg_active_bank); end
        drive_cfg(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0);
        checks++; if (cfg_bank_swap_pend !== 1'b1) begin errors++; $display("FAIL pend_set: got %b want 1", cfg_bank_swap_pend); end
        checks++; if (cfg_active_bank !== 1'b0) begin errors++; $display("FAIL pend_bank: got %b want 0", cfg_active_bank); end
        run_beat(4'd3, 4'd5, 128'h1, 1'b0, got, lat, p, h, v, l);
        checks++; if (h !== 32'h0 || got !== 1'b1) begin errors++; $display("FAIL pre_swap_coef_h: got %h want 00000000", h); end
        drive_cfg(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1);
        checks++; if (cfg_active_bank !== 1'b1) begin errors++; $display("FAIL swap_bank: got %b want 1", cfg_active_bank); end
        checks++; if (cfg_bank_swap_pend !== 1'b0) begin errors++; $display("FAIL swap_pend: got %b want 0", cfg_bank_swap_pend); end
        run_beat(4'd3, 4'd5, 128'h2, 1'b0, got, lat, p, h, v, l);
        checks++; if (h !== 32'h1020_3040) begin errors++; $display("FAIL load_coef_h: got %h want 10203040", h); end
        checks++; if (v !== 32'h0102_0304) begin errors++; $display("FAIL load_coef_v: got %h want 01020304", v); end
    endtask

    task automatic test_stream();
        int sent; int rcvd; logic prev_stall;
        logic [MAT_W-1:0] hold_pix; logic [ROW_W-1:0] hold_h; logic hold_last;
        sent = 0; rcvd = 0; prev_stall = 1'b0; hold_pix = '0; hold_h = '0; hold_last = 1'b0;
        s_axis_phase_h = 4'd3; s_axis_phase_v = 4'd5;
        for (int cyc = 0; cyc < 60 && rcvd < 8; cyc++) begin
            m_axis_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            s_axis_valid = (sent < 8);
            s_axis_pixel = {96'd0, 32'hB000_0000 + 32'(sent)};
            s_axis_last  = (sent == 7);
            #1;
            if (prev_stall) begin
                checks++;
                if (m_axis_valid !== 1'b1 || m_axis_pixel !== hold_pix || m_axis_coef_h !== hold_h || m_axis_last !== hold_last) begin
                    errors++; $display("FAIL stream_hold: got v=%b pix=%h want held pix=%h", m_axis_valid, m_axis_pixel, hold_pix);
                end
            end
            if (m_axis_valid && m_axis_ready) begin
                checks++;
                if (m_axis_pixel !== {96'd0, 32'hB000_0000 + 32'(rcvd)} || m_axis_last !== (rcvd == 7) || m_axis_coef_h !== 32'h1020_3040) begin
                    errors++; $display("FAIL stream_beat%0d: got pix=%h last=%b h=%h", rcvd, m_axis_pixel, m_axis_last, m_axis_coef_h);
                end
                rcvd++;
            end
            prev_stall = m_axis_valid && !m_axis_ready;
            hold_pix = m_axis_pixel; hold_h = m_axis_coef_h; hold_last = m_axis_last;
            if (s_axis_valid && s_axis_ready) sent++;
            @(posedge core_clk); #1;
        end
        s_axis_valid = 1'b0; s_axis_last = 1'b0; m_axis_ready = 1'b1;
        checks++; if (rcvd != 8 || sent != 8) begin errors++; $display("FAIL stream_count: got sent=%0d rcvd=%0d want 8/8", sent, rcvd); end
        repeat (3) begin
            checks++; if (m_axis_valid !== 1'b0) begin errors++; $display("FAIL stream_extra: got valid %b want 0", m_axis_valid); end
            @(posedge core_clk); #1;
        end
    endtask

    task automatic test_phase_oor();
        logic got; int lat; logic [MAT_W-1:0] p; logic [ROW_W-1:0] h, v; logic l;
        checks++; if (err_phase_oor !== 1'b0) begin errors++; $display("FAIL oor_initial: got %b want 0", err_phase_oor); end
        run_beat(4'd13, 4'd5, 128'h3, 1'b0, got, lat, p, h, v, l);
        checks++; if (h !== 32'h0 || got !== 1'b1) begin errors++; $display("FAIL oor13_coef_h: got %h want 00000000", h); end
        checks++; if (v !== 32'h0102_0304) begin errors++; $display("FAIL oor13_coef_v: got %h want 01020304", v); end
        checks++; if (err_phase_oor !== 1'b1) begin errors++; $display("FAIL oor13_err: got %b want 1", err_phase_oor); end
        run_beat(4'd12, 4'd5, 128'h4, 1'b0, got, lat, p, h, v, l);
        checks++; if (h !== 32'h0) begin errors++; $display("FAIL oor12_coef_h: got %h want 00000000", h); end
        run_beat(4'd3, 4'd5, 128'h5, 1'b0, got, lat, p, h, v, l);
        checks++; if (h !== 32'h1020_3040) begin errors++; $display("FAIL oor_after_coef_h: got %h want 10203040", h); end
        checks++; if (err_phase_oor !== 1'b1) begin errors++; $display("FAIL oor_sticky: got %b want 1", err_phase_oor); end
    endtask

    task automatic test_swap_same_cycle();
        logic got; int lat; logic [MAT_W-1:0] p; logic [ROW_W-1:0] h, v; logic l;
        run_beat(4'd3, 4'd5, 128'h6, 1'b0, got, lat, p, h, v, l);
        checks++; if (h !== 32'h1020_3040) begin errors++; $display("FAIL presw_coef_h: got %h want 10203040", h); end
        drive_cfg(1'b1, 1'b0, 4'd2, 32'hAABB_CCDD, 1'b1, 1'b1);
        checks++; if (cfg_active_bank !== 1'b0) begin errors++; $display("FAIL samecyc_bank: got %b want 0", cfg_active_bank); end
        checks++; if (cfg_bank_swap_pend !== 1'b0) begin errors++; $display("FAIL samecyc_pend: got %b want 0", cfg_bank_swap_pend); end
        run_beat(4'd2, 4'd5, 128'h7, 1'b0, got, lat, p, h, v, l);
        checks++; if (h !== 32'hAABB_CCDD) begin errors++; $display("FAIL samecyc_coef_h: got %h want aabbccdd", h); end
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL samecyc_coef_v: got %h want 00000000", v); end
        run_beat(4'd3, 4'd5, 128'h8, 1'b0, got, lat, p, h, v, l);
        checks++; if (h !== 32'h0) begin errors++; $display("FAIL samecyc_b0h3: got %h want 00000000", h); end
        drive_cfg(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0);
        drive_cfg(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0);
        checks++; if (cfg_bank_swap_pend !== 1'b1 || cfg_active_bank !== 1'b0) begin
            errors++; $display("FAIL double_req: got pend=%b bank=%b want 1/0", cfg_bank_swap_pend, cfg_active_bank);
        end
        drive_cfg(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1);
        drive_cfg(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1);
        checks++; if (cfg_active_bank !== 1'b1 || cfg_bank_swap_pend !== 1'b0) begin
            errors++; $display("FAIL single_toggle: got bank=%b pend=%b want 1/0", cfg_active_bank, cfg_bank_swap_pend);
        end
        run_beat(4'd2, 4'd5, 128'h9, 1'b0, got, lat, p, h, v, l);
        checks++; if (h !== 32'h0) begin errors++; $display("FAIL b1h2_untouched: got %h want 00000000", h); end
        checks++; if (v !== 32'h0102_0304) begin errors++; $display("FAIL b1v5_kept: got %h want 01020304", v); end
    endtask

    task automatic test_reset_inflight();
        logic got; int lat; logic [MAT_W-1:0] p; logic [ROW_W-1:0] h, v; logic l;
        m_axis_ready = 1'b1;
        s_axis_valid = 1'b1; s_axis_phase_h = 4'd3; s_axis_phase_v = 4'd5; s_axis_pixel = 128'hA1;
        @(posedge core_clk); #1;
        s_axis_pixel = 128'hA2; s_axis_last = 1'b1;
        @(posedge core_clk); #1;
        s_axis_valid = 1'b0; s_axis_last = 1'b0;
        checks++; if (m_axis_valid !== 1'b1) begin errors++; $display("FAIL inflight_valid: got %b want 1", m_axis_valid); end
        core_rst_n = 1'b0;
        @(posedge core_clk); #1;
        checks++; if (m_axis_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", m_axis_valid); end
        checks++; if (cfg_active_bank !== 1'b0 || err_phase_oor !== 1'b0 || m_axis_last !== 1'b0) begin
            errors++; $display("FAIL rstmid_state: got bank=%b err=%b last=%b want 0", cfg_active_bank, err_phase_oor, m_axis_last);
        end
        core_rst_n = 1'b1;
        @(posedge core_clk); #1;
        checks++; if (m_axis_valid !== 1'b0) begin errors++; $display("FAIL rstmid_flushed: got %b want 0", m_axis_valid); end
        run_beat(4'd3, 4'd5, 128'hB1, 1'b0, got, lat, p, h, v, l);
        checks++; if (h !== 32'h0 || v !== 32'h0 || got !== 1'b1) begin errors++; $display("FAIL rst_b0_clear: got h=%h v=%h want 0", h, v); end
        drive_cfg(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1);
        run_beat(4'd3, 4'd5, 128'hB2, 1'b0, got, lat, p, h, v, l);
        checks++; if (h !== 32'h0 || v !== 32'h0 || got !== 1'b1) begin errors++; $display("FAIL rst_b1_clear: got h=%h v=%h want 0", h, v); end
    endtask

    initial begin
        test_reset();
        test_zero_tables();
        test_load_swap();
        test_stream();
        test_phase_oor();
        test_swap_same_cycle();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
